laser_pulse_ctrl: RTL and testbench

Parametrised laser-pulse controller, the successor to the fixed 3-cycle laser timer FSM. A rising edge on the button input fires a pulse on x. The pulse length comes from a run-time input, and a mandatory cooldown follows every pulse. Optional retrigger extends a pulse in flight, a synchronous abort cuts a pulse short, and a counter records the shots fired. It sits between the debounced button synchroniser and the laser driver.

---
 rtl/laser_pulse_ctrl.sv | 113 +++++++++++
 tb/tb_laser_pulse_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/laser_pulse_ctrl.sv
// Laser-pulse controller: a button edge fires a pulse of run-time length on x,
// followed by a fixed cooldown; supports retrigger, abort and a shot counter.
module laser_pulse_ctrl #(
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned COOLDOWN  = 2,
    parameter int unsigned RETRIGGER = 0,
    parameter int unsigned SHOT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              b,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              x,
    output logic              busy,
    output logic              done,
    output logic [SHOT_W-1:0] shots
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        COOL = 2'd2
    } state_t;

    localparam logic             HAS_COOL  = (COOLDOWN != 0);
    localparam logic             RETRIG_EN = (RETRIGGER != 0);
    localparam logic [LEN_W-1:0] COOL_LOAD = HAS_COOL ? LEN_W'(COOLDOWN - 1) : '0;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              b_q;
    logic              x_q, x_d;
    logic              busy_q, busy_d;
    logic [SHOT_W-1:0] shots_q, shots_d;
    logic              done_c;
    logic              edge_c;
    logic              len_ok_c;

    assign edge_c   = b & ~b_q;
    assign len_ok_c = (len != '0);

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            b_q     <= 1'b0;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            shots_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b;
            x_q     <= x_d;
            busy_q  <= busy_d;
            shots_q <= shots_d;
        end
    end

    // Next-state, counter and completion strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shots_d = shots_q;
        done_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (edge_c && len_ok_c && !abort) begin
                    state_d = FIRE;
                    cnt_d   = len - LEN_W'(1);
                    shots_d = shots_q + SHOT_W'(1);
                end
            end
            FIRE: begin
                if (abort) begin
                    state_d = HAS_COOL ? COOL : IDLE;
                    cnt_d   = COOL_LOAD;
                end else if (RETRIG_EN && edge_c && len_ok_c) begin
                    cnt_d = len - LEN_W'(1);
                end else if (cnt_q == '0) begin
                    done_c  = 1'b1;
                    state_d = HAS_COOL ? COOL : IDLE;
                    cnt_d   = COOL_LOAD;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            COOL: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        x_d    = (state_d == FIRE);
        busy_d = (state_d != IDLE);
    end

    assign x     = x_q;
    assign busy  = busy_q;
    assign done  = done_c & ~reset;
    assign shots = shots_q;

endmodule

// File: tb/tb_laser_pulse_ctrl.sv
// Directed bench for laser_pulse_ctrl: three instances (default, retrigger,
// narrow shot counter with no cooldown) share stimulus; per-cycle traces are checked.
module tb_laser_pulse_ctrl;

    logic       clk;
    logic       reset;
    logic       b;
    logic [7:0] len;
    logic       abort;

    logic        x_m, busy_m, done_m;
    logic [15:0] shots_m;
    logic        x_r, busy_r, done_r;
    logic [15:0] shots_r;
    logic        x_w, busy_w, done_w;
    logic [1:0]  shots_w;

    laser_pulse_ctrl #(.LEN_W(8), .COOLDOWN(2), .RETRIGGER(0), .SHOT_W(16)) u_main (
        .clk(clk), .reset(reset), .b(b), .len(len), .abort(abort),
        .x(x_m), .busy(busy_m), .done(done_m), .shots(shots_m)
    );

    laser_pulse_ctrl #(.LEN_W(8), .COOLDOWN(2), .RETRIGGER(1), .SHOT_W(16)) u_rt (
        .clk(clk), .reset(reset), .b(b), .len(len), .abort(abort),
        .x(x_r), .busy(busy_r), .done(done_r), .shots(shots_r)
    );

    laser_pulse_ctrl #(.LEN_W(8), .COOLDOWN(0), .RETRIGGER(0), .SHOT_W(2)) u_w (
        .clk(clk), .reset(reset), .b(b), .len(len), .abort(abort),
        .x(x_w), .busy(busy_w), .done(done_w), .shots(shots_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Per-cycle traces: bit i holds the output during cycle i since the last clear
    logic [31:0] xm, dm, bm, xr, dr, br, xw, dw, bw;
    logic [5:0]  cidx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_trace();
        xm = '0; dm = '0; bm = '0;
        xr = '0; dr = '0; br = '0;
        xw = '0; dw = '0; bw = '0;
        cidx = '0;
    endtask

    // One clock cycle: apply inputs after the edge, then sample that cycle's outputs
    task automatic cyc(input logic ri, input logic bi, input logic ai, input logic [7:0] li);
        @(posedge clk);
        #1;
        reset = ri;
        b     = bi;
        abort = ai;
        len   = li;
        #1;
        if (!cidx[5]) begin
            xm[cidx[4:0]] = x_m; dm[cidx[4:0]] = done_m; bm[cidx[4:0]] = busy_m;
            xr[cidx[4:0]] = x_r; dr[cidx[4:0]] = done_r; br[cidx[4:0]] = busy_r;
            xw[cidx[4:0]] = x_w; dw[cidx[4:0]] = done_w; bw[cidx[4:0]] = busy_w;
        end
        if (cidx != 6'd63) cidx = cidx + 6'd1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 8'd3);
        cyc(1'b1, 1'b0, 1'b0, 8'd3);
        clear_trace();
    endtask

    initial begin
        reset = 1'b1; b = 1'b0; abort = 1'b0; len = 8'd3;
        clear_trace();

        // Reset state
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 8'd3);
        check("rst_x",     32'(x_m),     32'd0);
        check("rst_busy",  32'(busy_m),  32'd0);
        check("rst_done",  32'(done_m),  32'd0);
        check("rst_shots", 32'(shots_m), 32'd0);

        // Basic 3-cycle pulse; len change mid-pulse has no effect
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 8'd3);
        repeat (13) cyc(1'b0, 1'b0, 1'b0, 8'd7);
        check("t1_x",     xm, 32'h0000_000E);
        check("t1_done",  dm, 32'h0000_0008);
        check("t1_busy",  bm, 32'h0000_003E);
        check("t1_shots", 32'(shots_m), 32'd1);

        // Held button gives one pulse; a new edge later gives another
        do_reset();
        repeat (20) cyc(1'b0, 1'b1, 1'b0, 8'd3);
        repeat (8)  cyc(1'b0, 1'b0, 1'b0, 8'd3);
        check("t2_x_held",  xm, 32'h0000_000E);
        check("t2_shots1",  32'(shots_m), 32'd1);
        clear_trace();
        cyc(1'b0, 1'b1, 1'b0, 8'd3);
        repeat (6) cyc(1'b0, 1'b0, 1'b0, 8'd3);
        check("t2_x_again", xm, 32'h0000_000E);
        check("t2_shots2",  32'(shots_m), 32'd2);

        // len=0 ignored; abort alongside the edge wins
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 8'd0);
        repeat (6) cyc(1'b0, 1'b0, 1'b0, 8'd0);
        check("t3_len0_x",     xm, 32'h0);
        check("t3_len0_busy",  bm, 32'h0);
        check("t3_len0_done",  dm, 32'h0);
        check("t3_len0_shots", 32'(shots_m), 32'd0);
        clear_trace();
        cyc(1'b0, 1'b1, 1'b1, 8'd3);
        repeat (6) cyc(1'b0, 1'b0, 1'b0, 8'd3);
        check("t3_abort_busy",  bm, 32'h0);
        check("t3_abort_shots", 32'(shots_m), 32'd0);

        // Retrigger: second edge two cycles in
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 8'd4);
        cyc(1'b0, 1'b0, 1'b0, 8'd4);
        cyc(1'b0, 1'b1, 1'b0, 8'd4);
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 8'd4);
        check("t4_norm_x",    xm, 32'h0000_001E);
        check("t4_norm_done", dm, 32'h0000_0010);
        check("t4_rt_x",      xr, 32'h0000_007E);
        check("t4_rt_done",   dr, 32'h0000_0040);
        check("t4_rt_shots",  32'(shots_r), 32'd1);

        // Abort mid-pulse, edge during cooldown is lost
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 8'd10);
        cyc(1'b0, 1'b0, 1'b0, 8'd10);
        cyc(1'b0, 1'b0, 1'b0, 8'd10);
        cyc(1'b0, 1'b0, 1'b1, 8'd10);
        cyc(1'b0, 1'b1, 1'b0, 8'd10);
        repeat (8) cyc(1'b0, 1'b0, 1'b0, 8'd10);
        check("t5_x",     xm, 32'h0000_000E);
        check("t5_done",  dm, 32'h0);
        check("t5_busy",  bm, 32'h0000_003E);
        check("t5_shots", 32'(shots_m), 32'd1);

        // Reset mid-pulse with b held high across it
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 8'd8);
        cyc(1'b0, 1'b1, 1'b0, 8'd8);
        cyc(1'b1, 1'b1, 1'b0, 8'd8);
        cyc(1'b1, 1'b1, 1'b0, 8'd8);
        check("t6_x_after_rst",     32'(x_m),     32'd0);
        check("t6_shots_after_rst", 32'(shots_m), 32'd0);
        repeat (20) cyc(1'b0, 1'b1, 1'b0, 8'd8);
        repeat (2)  cyc(1'b0, 1'b0, 1'b0, 8'd8);
        check("t6_x",     xm, 32'h0000_1FE6);
        check("t6_done",  dm, 32'h0000_1000);
        check("t6_shots", 32'(shots_m), 32'd1);

        // Shot counter wrap on the 2-bit instance
        do_reset();
        repeat (5) begin
            cyc(1'b0, 1'b1, 1'b0, 8'd1);
            repeat (4) cyc(1'b0, 1'b0, 1'b0, 8'd1);
        end
        check("t7_shots_wrap", 32'(shots_w), 32'd1);
        check("t7_shots_main", 32'(shots_m), 32'd5);

        // No cooldown: an edge in the last FIRE cycle is ignored
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 8'd2);
        cyc(1'b0, 1'b0, 1'b0, 8'd2);
        repeat (8) cyc(1'b0, 1'b1, 1'b0, 8'd2);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'd2);
        check("t8_x",     xw, 32'h0000_0006);
        check("t8_done",  dw, 32'h0000_0004);
        check("t8_busy",  bw, 32'h0000_0006);
        check("t8_shots", 32'(shots_w), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
